// File: rtl/br_pkg.sv
// Shared types and constants for the branch predictor.
// Counter encoding and branch funct3 decode values.
package br_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic ctr_taken(input ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/br_if.sv
// Fetch/EX bundle between the pipeline and the branch predictor.
// master = pipeline side, slave = predictor.
interface br_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      i_if_pc;
    logic             o_pred_hit;
    logic             o_pred_taken;
    logic [31:0]      o_pred_target;
    logic             i_ex_valid;
    logic             i_ex_is_branch;
    logic [31:0]      i_ex_pc;
    logic [31:0]      i_ex_target;
    logic [2:0]       i_ex_funct3;
    logic             i_br_less;
    logic             i_br_equal;
    logic             i_ex_pred_taken;
    logic [31:0]      i_ex_pred_target;
    logic             o_ex_taken;
    logic             o_mispredict;
    logic [31:0]      o_redirect_pc;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    modport master (
        output i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_pc,
        output i_ex_target, i_ex_funct3, i_br_less, i_br_equal,
        output i_ex_pred_taken, i_ex_pred_target,
        input  o_pred_hit, o_pred_taken, o_pred_target,
        input  o_ex_taken, o_mispredict, o_redirect_pc,
        input  o_br_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_pc,
        input  i_ex_target, i_ex_funct3, i_br_less, i_br_equal,
        input  i_ex_pred_taken, i_ex_pred_target,
        output o_pred_hit, o_pred_taken, o_pred_target,
        output o_ex_taken, o_mispredict, o_redirect_pc,
        output o_br_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/br_sat_ctr.sv
// 2-bit saturating counter next-state logic.
// Counts toward ST when i_inc, toward SNT otherwise.
module br_sat_ctr
    import br_pkg::*;
(
    input  ctr_e i_cnt,
    input  logic i_inc,
    output ctr_e o_cnt
);

    // Saturating step in the direction of the resolved outcome
    always_comb begin
        o_cnt = i_cnt;
        unique case (i_cnt)
            SNT: o_cnt = i_inc ? WNT : SNT;
            WNT: o_cnt = i_inc ? WT  : SNT;
            WT:  o_cnt = i_inc ? ST  : WNT;
            ST:  o_cnt = i_inc ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts at IF,
// resolves, redirects and trains at EX.
module branch_predictor
    import br_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input logic   i_clk,
    input logic   i_rst_n,
    br_if.slave   bp
);

    localparam int TAG_W   = 30 - INDEX_W;
    localparam int ENTRIES = 1 << INDEX_W;

    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0]   tag_t;

    logic [ENTRIES-1:0] valid_q;
    tag_t               tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    ctr_e               ctr_q [ENTRIES];

    idx_t       if_idx;
    idx_t       ex_idx;
    tag_t       if_tag;
    tag_t       ex_tag;
    logic       if_hit;
    logic       ex_hit;
    logic       res;
    logic       legal;
    logic       dir;
    logic       upd;
    logic       mispredict;
    ctr_e       ctr_nxt;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;
    logic       unused_if_lsb;

    assign unused_if_lsb = ^bp.i_if_pc[1:0];

    assign if_idx = bp.i_if_pc[INDEX_W+1:2];
    assign if_tag = bp.i_if_pc[31:INDEX_W+2];
    assign ex_idx = bp.i_ex_pc[INDEX_W+1:2];
    assign ex_tag = bp.i_ex_pc[31:INDEX_W+2];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign bp.o_pred_hit    = if_hit;
    assign bp.o_pred_taken  = if_hit && ctr_taken(ctr_q[if_idx]);
    assign bp.o_pred_target = if_hit ? tgt_q[if_idx] : 32'b0;

    // Actual direction from comparator flags; flags illegal funct3
    always_comb begin
        legal = 1'b1;
        dir   = 1'b0;
        unique case (bp.i_ex_funct3)
            F3_BEQ:           dir = bp.i_br_equal;
            F3_BNE:           dir = !bp.i_br_equal;
            F3_BLT, F3_BLTU:  dir = bp.i_br_less;
            F3_BGE, F3_BGEU:  dir = !bp.i_br_less;
            default:          legal = 1'b0;
        endcase
    end

    assign res = bp.i_ex_valid && bp.i_ex_is_branch;
    assign upd = res && legal;

    assign mispredict = upd &&
        ((dir != bp.i_ex_pred_taken) ||
         (dir && (bp.i_ex_pred_target != bp.i_ex_target)));

    assign bp.o_ex_taken    = res && dir;
    assign bp.o_mispredict  = mispredict;
    assign bp.o_redirect_pc = !res ? 32'b0 :
                              dir  ? bp.i_ex_target :
                                     bp.i_ex_pc + 32'd4;

    br_sat_ctr u_sat_ctr (
        .i_cnt (ctr_q[ex_idx]),
        .i_inc (dir),
        .o_cnt (ctr_nxt)
    );

    // Valid bits: cleared on reset, set on allocation
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
        end else if (upd && !ex_hit && dir) begin
            valid_q[ex_idx] <= 1'b1;
        end
    end

    // Entry payload: train on hit, allocate on taken miss
    always_ff @(posedge i_clk) begin
        if (upd) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_nxt;
                if (dir) begin
                    tgt_q[ex_idx] <= bp.i_ex_target;
                end
            end else if (dir) begin
                tag_q[ex_idx] <= ex_tag;
                tgt_q[ex_idx] <= bp.i_ex_target;
                ctr_q[ex_idx] <= WT;
            end
        end
    end

    // Saturating perf counters for resolved branches and mispredicts
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (upd && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + 1'b1;
            end
            if (mispredict && (mis_cnt_q != '1)) begin
                mis_cnt_q <= mis_cnt_q + 1'b1;
            end
        end
    end

    assign bp.o_br_cnt      = br_cnt_q;
    assign bp.o_mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor with an expected-value
// queue: rows are pushed when driven and popped when sampled.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    br_if #(.CNT_W(32)) bp ();

    branch_predictor #(
        .INDEX_W (6),
        .CNT_W   (32)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bp      (bp.slave)
    );

    typedef struct {
        logic        hit;
        logic        ptk;
        logic [31:0] ptgt;
        logic        tk;
        logic        mis;
        logic [31:0] rd;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    typedef struct {
        logic [31:0] if_pc;
        logic        ev;
        logic        br;
        logic [31:0] ex_pc;
        logic [31:0] tgt;
        logic [2:0]  f3;
        logic        less;
        logic        eq;
        logic        pt;
        logic [31:0] ptgt;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic [31:0] if_pc, input logic ev, input logic br,
        input logic [31:0] ex_pc, input logic [31:0] tgt,
        input logic [2:0] f3, input logic less, input logic eq,
        input logic pt, input logic [31:0] ptgt,
        input logic hit, input logic ptk, input logic [31:0] optgt,
        input logic tk, input logic mis, input logic [31:0] rd,
        input logic [31:0] bc, input logic [31:0] mc
    );
        vec_t v;
        v.if_pc = if_pc; v.ev = ev; v.br = br; v.ex_pc = ex_pc;
        v.tgt = tgt; v.f3 = f3; v.less = less; v.eq = eq;
        v.pt = pt; v.ptgt = ptgt;
        v.e.hit = hit; v.e.ptk = ptk; v.e.ptgt = optgt;
        v.e.tk = tk; v.e.mis = mis; v.e.rd = rd;
        v.e.bc = bc; v.e.mc = mc;
        return v;
    endfunction

    function automatic vec_t idle(
        input logic [31:0] if_pc, input logic hit, input logic ptk,
        input logic [31:0] optgt, input logic [31:0] bc,
        input logic [31:0] mc
    );
        return mk(if_pc, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0,
                  1'b0, 1'b0, 1'b0, 32'h0,
                  hit, ptk, optgt, 1'b0, 1'b0, 32'h0, bc, mc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bp.i_if_pc          = v.if_pc;
        bp.i_ex_valid       = v.ev;
        bp.i_ex_is_branch   = v.br;
        bp.i_ex_pc          = v.ex_pc;
        bp.i_ex_target      = v.tgt;
        bp.i_ex_funct3      = v.f3;
        bp.i_br_less        = v.less;
        bp.i_br_equal       = v.eq;
        bp.i_ex_pred_taken  = v.pt;
        bp.i_ex_pred_target = v.ptgt;
        sb.push_back(v.e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".hit"},  {31'b0, bp.o_pred_hit},   {31'b0, e.hit});
            chk({tag, ".ptk"},  {31'b0, bp.o_pred_taken}, {31'b0, e.ptk});
            chk({tag, ".ptgt"}, bp.o_pred_target,         e.ptgt);
            chk({tag, ".tk"},   {31'b0, bp.o_ex_taken},   {31'b0, e.tk});
            chk({tag, ".mis"},  {31'b0, bp.o_mispredict}, {31'b0, e.mis});
            chk({tag, ".rd"},   bp.o_redirect_pc,         e.rd);
            chk({tag, ".bc"},   bp.o_br_cnt,              e.bc);
            chk({tag, ".mc"},   bp.o_mispred_cnt,         e.mc);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(idle(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // idle lookup after reset
        vecs.push_back(idle(32'h100, 0, 0, 32'h0, 0, 0));
        // BEQ taken, predicted not taken: allocate WT
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 32'h140, 3'b000,
            0, 1, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h140, 0, 0));
        vecs.push_back(idle(32'h100, 1, 1, 32'h140, 1, 1));
        // not taken, same-cycle lookup sees old WT entry
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 32'h140, 3'b000,
            0, 0, 1, 32'h140, 1, 1, 32'h140, 0, 1, 32'h104, 1, 1));
        // WNT -> SNT, predicted not taken correctly
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 32'h140, 3'b000,
            0, 0, 0, 32'h140, 1, 0, 32'h140, 0, 0, 32'h104, 2, 2));
        // SNT saturates
        vecs.push_back(mk(32'h100, 1, 1, 32'h100, 32'h140, 3'b000,
            0, 0, 0, 32'h140, 1, 0, 32'h140, 0, 0, 32'h104, 3, 2));
        vecs.push_back(idle(32'h100, 1, 0, 32'h140, 4, 2));
        // BLTU less=1 taken
        vecs.push_back(mk(32'h300, 1, 1, 32'h304, 32'h380, 3'b110,
            1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h380, 4, 2));
        // BGEU less=1 not taken
        vecs.push_back(mk(32'h304, 1, 1, 32'h308, 32'h3a0, 3'b111,
            1, 0, 0, 32'h0, 1, 1, 32'h380, 0, 0, 32'h30c, 5, 3));
        // illegal funct3 010: no update, not counted
        vecs.push_back(mk(32'h308, 1, 1, 32'h30c, 32'h999, 3'b010,
            1, 1, 1, 32'h999, 0, 0, 32'h0, 0, 0, 32'h310, 6, 3));
        vecs.push_back(idle(32'h30c, 0, 0, 32'h0, 6, 3));
        // alias: taken at 0x200 evicts 0x100
        vecs.push_back(mk(32'h100, 1, 1, 32'h200, 32'h240, 3'b000,
            0, 1, 0, 32'h0, 1, 0, 32'h140, 1, 1, 32'h240, 6, 3));
        vecs.push_back(idle(32'h100, 0, 0, 32'h0, 7, 4));
        vecs.push_back(idle(32'h200, 1, 1, 32'h240, 7, 4));
        // right direction, wrong target
        vecs.push_back(mk(32'h200, 1, 1, 32'h200, 32'h240, 3'b000,
            0, 1, 1, 32'h250, 1, 1, 32'h240, 1, 1, 32'h240, 7, 4));
        // correct prediction
        vecs.push_back(mk(32'h200, 1, 1, 32'h200, 32'h240, 3'b000,
            0, 1, 1, 32'h240, 1, 1, 32'h240, 1, 0, 32'h240, 8, 5));
        // bubble: outputs zero, no training
        vecs.push_back(mk(32'h200, 0, 1, 32'h200, 32'h240, 3'b000,
            0, 1, 0, 32'h0, 1, 1, 32'h240, 0, 0, 32'h0, 9, 5));
        // BNE taken
        vecs.push_back(mk(32'h204, 1, 1, 32'h204, 32'h400, 3'b001,
            0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h400, 9, 5));
        // BLT less=0 not taken
        vecs.push_back(mk(32'h204, 1, 1, 32'h208, 32'h600, 3'b100,
            0, 0, 0, 32'h0, 1, 1, 32'h400, 0, 0, 32'h20c, 10, 6));
        // BGE less=0 taken, predicted correctly
        vecs.push_back(mk(32'h208, 1, 1, 32'h20c, 32'h500, 3'b101,
            0, 0, 1, 32'h500, 0, 0, 32'h0, 1, 0, 32'h500, 11, 6));
        vecs.push_back(idle(32'h20c, 1, 1, 32'h500, 12, 6));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // reset mid-stream with a taken branch in EX
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(mk(32'h200, 1, 1, 32'h208, 32'h700, 3'b000,
            0, 1, 0, 32'h0, 1, 1, 32'h240, 1, 1, 32'h700, 12, 6));
        @(negedge clk);
        compare("rst_in");
        step(idle(32'h200, 0, 0, 32'h0, 0, 0), "rst0");
        #1;
        rst_n = 1'b1;
        step(idle(32'h204, 0, 0, 32'h0, 0, 0), "rst1");
        step(idle(32'h20c, 0, 0, 32'h0, 0, 0), "rst2");
        step(idle(32'h208, 0, 0, 32'h0, 0, 0), "rst3");

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
